// File: rtl/mgmt_phy_train_monitor.sv
// mgmt_phy_train_monitor: lock, count, timeout and error qualifiers derived from training frames for the PHY management controller
typedef enum logic [3:0] {
    ST_INIT,
    ST_COMMA_HUNTING,
    ST_WAIT_LINK_DETECT_LOCKED,
    ST_WAIT_LINK_SPEED_LOCKED,
    ST_WAIT_LINK_ADVERTISE_LOCKED,
    ST_WAIT_IN_ADVERTISE,
    ST_CONFIGURATION_OR_ACCEPT,
    ST_OPERATIONAL,
    ST_LINK_LOST_ERR
} rstate_t;

localparam int TIMER_1MS_60MHZ = 60000;

module mgmt_phy_train_monitor #(
    parameter int DETECT_LOCK_CNT   = 7,
    parameter int DETECT_TX_CNT     = 255,
    parameter int SPEED_TX_CNT      = 7,
    parameter int ADV_LOCK_CNT      = 7,
    parameter int CRC_LOSS_CNT      = 3,
    parameter int SPEED_TIMEOUT_CYC = TIMER_1MS_60MHZ
) (
    input  logic       clk,
    input  logic       reset,
    input  rstate_t    link_st,
    input  logic       rx_frm_valid,
    input  logic [3:0] rx_frm_type,
    input  logic       rx_frm_crc_err,
    input  logic       tx_frm_done,
    input  logic [3:0] tx_frm_type,
    output logic       link_detect_locked,
    output logic       transmited_255_detect_frm,
    output logic       transmited_7_speed_frm,
    output logic       link_speed_timeout_detect,
    output logic       crc_consec_loss,
    output logic       advertise_locked,
    output logic       unexpected_frame_error
);
    localparam logic [3:0] FT_DETECT = 4'd0;
    localparam logic [3:0] FT_SPEED  = 4'd1;
    localparam logic [3:0] FT_ADV    = 4'd2;
    localparam logic [3:0] FT_CFG    = 4'd3;
    localparam logic [3:0] FT_ACCEPT = 4'd4;
    localparam logic [3:0] FT_DIO    = 4'd5;
    localparam logic [3:0] FT_DATA   = 4'd6;
    localparam int DRW = $clog2(DETECT_LOCK_CNT + 1);
    localparam int STW = $clog2(SPEED_TX_CNT + 1);
    localparam int CYW = $clog2(SPEED_TIMEOUT_CYC + 1);
    localparam int ARW = $clog2(ADV_LOCK_CNT + 1);
    localparam int CRW = $clog2(CRC_LOSS_CNT + 1);
    localparam logic [DRW-1:0] DET_LOCK = DRW'(DETECT_LOCK_CNT);
    localparam logic [7:0]     DET_TX   = 8'(DETECT_TX_CNT);
    localparam logic [STW-1:0] SPD_TX   = STW'(SPEED_TX_CNT);
    localparam logic [CYW-1:0] SPD_TO   = CYW'(SPEED_TIMEOUT_CYC);
    localparam logic [ARW-1:0] ADV_LOCK = ARW'(ADV_LOCK_CNT);
    localparam logic [CRW-1:0] CRC_LIM  = CRW'(CRC_LOSS_CNT);

    rstate_t        link_st_q;
    logic [DRW-1:0] det_rx_q, det_rx_d;
    logic [7:0]     det_tx_q, det_tx_d;
    logic [STW-1:0] spd_tx_q, spd_tx_d;
    logic [CYW-1:0] spd_cyc_q, spd_cyc_d;
    logic [ARW-1:0] adv_rx_q, adv_rx_d;
    logic [CRW-1:0] crc_q, crc_d;
    logic spd_seen_q, spd_seen_d;
    logic det_lock_q, det_lock_d, tx255_q, tx255_d, tx7_q, tx7_d, timeout_q, timeout_d;
    logic crc_loss_q, crc_loss_d, adv_lock_q, adv_lock_d, unexp_q, unexp_d;
    logic good, bad, chg, in_det, in_spd, in_adv, in_wadv, in_cfg, in_op, det_zone, adv_zone;
    logic crc_act, checked, allowed;
    logic ft_det, ft_spd, ft_adv, ft_cfg, ft_acc, ft_dio, ft_data;

    always_comb begin
        good     = rx_frm_valid & ~rx_frm_crc_err;
        bad      = rx_frm_valid & rx_frm_crc_err;
        chg      = link_st != link_st_q;
        in_det   = link_st == ST_WAIT_LINK_DETECT_LOCKED;
        in_spd   = link_st == ST_WAIT_LINK_SPEED_LOCKED;
        in_adv   = link_st == ST_WAIT_LINK_ADVERTISE_LOCKED;
        in_wadv  = link_st == ST_WAIT_IN_ADVERTISE;
        in_cfg   = link_st == ST_CONFIGURATION_OR_ACCEPT;
        in_op    = link_st == ST_OPERATIONAL;
        det_zone = in_det | in_spd;
        adv_zone = in_adv | in_wadv | in_cfg;
        crc_act  = !(link_st inside {ST_INIT, ST_COMMA_HUNTING, ST_LINK_LOST_ERR});
        ft_det   = rx_frm_type == FT_DETECT;
        ft_spd   = rx_frm_type == FT_SPEED;
        ft_adv   = rx_frm_type == FT_ADV;
        ft_cfg   = rx_frm_type == FT_CFG;
        ft_acc   = rx_frm_type == FT_ACCEPT;
        ft_dio   = rx_frm_type == FT_DIO;
        ft_data  = rx_frm_type == FT_DATA;
        // State-owned counters sit at zero outside their state, so entry always starts from a clean count
        det_rx_d   = (!in_det || bad) ? '0 :
                     (good && ft_det && det_rx_q != DET_LOCK) ? det_rx_q + 1'b1 : det_rx_q;
        det_lock_d = det_zone & (det_lock_q | (det_rx_d == DET_LOCK));
        det_tx_d   = !in_det ? '0 :
                     (tx_frm_done && tx_frm_type == FT_DETECT && !(&det_tx_q)) ? det_tx_q + 1'b1 : det_tx_q;
        tx255_d    = det_zone & (tx255_q | (det_tx_d >= DET_TX));
        spd_tx_d   = !in_spd ? '0 :
                     (tx_frm_done && tx_frm_type == FT_SPEED && spd_tx_q != SPD_TX) ? spd_tx_q + 1'b1 : spd_tx_q;
        spd_seen_d = in_spd & (spd_seen_q | (good & ft_spd));
        spd_cyc_d  = !in_spd ? '0 : (spd_seen_d || spd_cyc_q == SPD_TO) ? spd_cyc_q : spd_cyc_q + 1'b1;
        timeout_d  = in_spd & (timeout_q | (spd_cyc_d == SPD_TO & ~spd_seen_d));
        tx7_d      = in_spd & spd_seen_d & (spd_tx_d >= SPD_TX);
        adv_rx_d   = (!in_adv || bad || (good && !ft_adv)) ? '0 :
                     (good && adv_rx_q != ADV_LOCK) ? adv_rx_q + 1'b1 : adv_rx_q;
        adv_lock_d = in_adv ? ((adv_lock_q & ~chg) | (adv_rx_d == ADV_LOCK)) : (adv_zone & adv_lock_q);
        crc_d      = (!crc_act || good) ? '0 : (bad && crc_q != CRC_LIM) ? crc_q + 1'b1 : crc_q;
        crc_loss_d = (link_st != ST_INIT) & (crc_loss_q | (crc_d == CRC_LIM));
        checked    = det_zone | in_adv | in_wadv | in_cfg | in_op;
        allowed    = det_zone ? (ft_det | ft_spd) :
                     (in_adv | in_wadv) ? (ft_adv | ft_spd) :
                     in_cfg ? (ft_adv | ft_cfg | ft_acc) : (ft_dio | ft_data);
        unexp_d    = good & checked & ~allowed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_st_q  <= ST_INIT;
            det_rx_q   <= '0;
            det_tx_q   <= '0;
            spd_tx_q   <= '0;
            spd_cyc_q  <= '0;
            adv_rx_q   <= '0;
            crc_q      <= '0;
            spd_seen_q <= 1'b0;
            det_lock_q <= 1'b0;
            tx255_q    <= 1'b0;
            tx7_q      <= 1'b0;
            timeout_q  <= 1'b0;
            crc_loss_q <= 1'b0;
            adv_lock_q <= 1'b0;
            unexp_q    <= 1'b0;
        end else begin
            link_st_q  <= link_st;
            det_rx_q   <= det_rx_d;
            det_tx_q   <= det_tx_d;
            spd_tx_q   <= spd_tx_d;
            spd_cyc_q  <= spd_cyc_d;
            adv_rx_q   <= adv_rx_d;
            crc_q      <= crc_d;
            spd_seen_q <= spd_seen_d;
            det_lock_q <= det_lock_d;
            tx255_q    <= tx255_d;
            tx7_q      <= tx7_d;
            timeout_q  <= timeout_d;
            crc_loss_q <= crc_loss_d;
            adv_lock_q <= adv_lock_d;
            unexp_q    <= unexp_d;
        end
    end

    assign link_detect_locked        = det_lock_q;
    assign transmited_255_detect_frm = tx255_q;
    assign transmited_7_speed_frm    = tx7_q;
    assign link_speed_timeout_detect = timeout_q;
    assign crc_consec_loss           = crc_loss_q;
    assign advertise_locked          = adv_lock_q;
    assign unexpected_frame_error    = unexp_q;
endmodule
